// File: rtl/dino_game_sequencer.sv
// dino_game_sequencer: frame-rate game logic for the dinosaur runner.
// Owns the INIT/GAME/DONE state machine, dino jump physics, single-obstacle
// spawn/scroll, collision detection and the cleared-obstacle score.
//
// Ports:
//   clk              pixel clock
//   rst              asynchronous, active-high reset
//   up               jump/start button (level; rising edge is used)
//   hCount, vCount   VGA counters; the frame tick fires at (FRAME_LINE, 0)
//   dino_y           dino bottom edge y
//   obs_x            obstacle left edge x
//   obs_valid        obstacle on screen
//   score            obstacles cleared, saturating
//   q_I/q_Game/q_Done one-hot state flags
//
// Build option: define SPEEDUP_EN to raise the scroll speed by 1 every
// 8 points (capped at SCROLL+4). Undefined, the speed is the constant SCROLL.

module dino_game_sequencer #(
  parameter int unsigned DINO_X     = 200,
  parameter int unsigned SIZE       = 50,
  parameter int unsigned GROUND_Y   = 515,
  parameter int unsigned SCREEN_L   = 144,
  parameter int unsigned SCREEN_R   = 783,
  parameter int unsigned FRAME_LINE = 524,
  parameter int unsigned JUMP_V     = 12,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned SCROLL     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        up,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [9:0]  dino_y,
  output logic [9:0]  obs_x,
  output logic        obs_valid,
  output logic [15:0] score,
  output logic        q_I,
  output logic        q_Game,
  output logic        q_Done
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned EXT_W   = POS_W + 1;
  localparam int unsigned VEL_W   = 6;
  localparam int unsigned SCORE_W = 16;
  localparam int unsigned LFSR_W  = 8;
  localparam int unsigned GAP_W   = 8;
  localparam int unsigned GAP_MIN = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

  // One-hot encoding so the q_* flags are straight flop outputs
  typedef enum logic [2:0] {
    S_INIT = 3'b001,
    S_GAME = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t                    state, state_n;
  logic                      up_q;
  logic signed [VEL_W-1:0]   vel, vel_n;
  logic [LFSR_W-1:0]         lfsr, lfsr_n;
  logic [GAP_W-1:0]          gap, gap_n;
  logic                      jump_req, jump_req_n;
  logic [POS_W-1:0]          dino_y_n, obs_x_n;
  logic                      obs_valid_n;
  logic [SCORE_W-1:0]        score_n;

  logic                      up_edge_c;
  logic                      tick_c;
  logic                      jump_pend_c;
  logic                      grounded_c;
  logic [EXT_W-1:0]          y_calc_c;
  logic [POS_W-1:0]          speed_c;
  logic [POS_W-1:0]          despawn_thr_c;
  logic [GAP_W-1:0]          gap_seed_c;
  logic                      hit_c;

  assign q_I    = state[0];
  assign q_Game = state[1];
  assign q_Done = state[2];

  // Button edge and per-frame tick
  assign up_edge_c = up & ~up_q;
  assign tick_c    = (vCount == POS_W'(FRAME_LINE)) && (hCount == '0);

  // Spawn delay drawn from the LFSR: 16..79 ticks
  assign gap_seed_c = GAP_W'({2'b00, lfsr[5:0]}) + GAP_W'(GAP_MIN);

`ifdef SPEEDUP_EN
  // Speed bonus: one step per 8 points, at most 4
  logic [SCORE_W-4:0] level_c;
  logic [2:0]         bonus_c;
  assign level_c = score[SCORE_W-1:3];
  assign bonus_c = (level_c > (SCORE_W-3)'(4)) ? 3'd4 : level_c[2:0];
  assign speed_c = POS_W'(SCROLL) + POS_W'(bonus_c);
`else
  assign speed_c = POS_W'(SCROLL);
`endif

  assign despawn_thr_c = POS_W'(SCREEN_L) + speed_c;

  // Airborne position update; vel is signed, so sign-extend before subtracting
  assign grounded_c = (dino_y == POS_W'(GROUND_Y)) && (vel == '0);
  assign y_calc_c   = {1'b0, dino_y} - {{(EXT_W-VEL_W){vel[VEL_W-1]}}, vel};

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    vel_n       = vel;
    lfsr_n      = lfsr;
    gap_n       = gap;
    jump_req_n  = jump_req;
    dino_y_n    = dino_y;
    obs_x_n     = obs_x;
    obs_valid_n = obs_valid;
    score_n     = score;
    jump_pend_c = 1'b0;
    hit_c       = 1'b0;

    // LFSR runs every frame regardless of state (taps 8,6,5,4)
    if (tick_c) begin
      lfsr_n = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    case (state)
      S_INIT: begin
        dino_y_n    = POS_W'(GROUND_Y);
        vel_n       = '0;
        obs_x_n     = POS_W'(SCREEN_R);
        obs_valid_n = 1'b0;
        score_n     = '0;
        jump_req_n  = 1'b0;
        gap_n       = '0;
        if (up_edge_c) begin
          state_n = S_GAME;
          gap_n   = gap_seed_c;
        end
      end

      S_GAME: begin
        // A press in the same cycle as the tick counts for that tick
        jump_pend_c = jump_req | up_edge_c;
        jump_req_n  = jump_pend_c;

        if (tick_c) begin
          // Jump physics
          if (grounded_c) begin
            if (jump_pend_c) begin
              vel_n      = VEL_W'(JUMP_V);
              jump_req_n = 1'b0;
            end
          end else if (y_calc_c >= EXT_W'(GROUND_Y)) begin
            // Landing; a jump queued in the air launches right here
            dino_y_n = POS_W'(GROUND_Y);
            if (jump_pend_c) begin
              vel_n      = VEL_W'(JUMP_V);
              jump_req_n = 1'b0;
            end else begin
              vel_n = '0;
            end
          end else begin
            dino_y_n = y_calc_c[POS_W-1:0];
            vel_n    = vel - VEL_W'(GRAVITY);
          end

          // Obstacle spawn / scroll / despawn
          if (!obs_valid) begin
            if (gap <= GAP_W'(1)) begin
              gap_n       = '0;
              obs_valid_n = 1'b1;
              obs_x_n     = POS_W'(SCREEN_R);
            end else begin
              gap_n = gap - GAP_W'(1);
            end
          end else if (obs_x < despawn_thr_c) begin
            obs_valid_n = 1'b0;
            score_n     = (score == '1) ? score : score + SCORE_W'(1);
            gap_n       = gap_seed_c;
          end else begin
            obs_x_n = obs_x - speed_c;
          end

          // Overlap test on the post-update positions
          hit_c = obs_valid_n &&
                  (obs_x_n < POS_W'(DINO_X + SIZE)) &&
                  (({1'b0, obs_x_n} + EXT_W'(SIZE)) > EXT_W'(DINO_X)) &&
                  (dino_y_n > POS_W'(GROUND_Y - SIZE));
          if (hit_c) begin
            state_n    = S_DONE;
            jump_req_n = 1'b0;
          end
        end
      end

      S_DONE: begin
        jump_req_n = 1'b0;
        if (up_edge_c) begin
          state_n     = S_INIT;
          dino_y_n    = POS_W'(GROUND_Y);
          vel_n       = '0;
          obs_x_n     = POS_W'(SCREEN_R);
          obs_valid_n = 1'b0;
          score_n     = '0;
          gap_n       = '0;
        end
      end

      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      up_q      <= 1'b0;
      vel       <= '0;
      lfsr      <= LFSR_SEED;
      gap       <= '0;
      jump_req  <= 1'b0;
      dino_y    <= POS_W'(GROUND_Y);
      obs_x     <= POS_W'(SCREEN_R);
      obs_valid <= 1'b0;
      score     <= '0;
    end else begin
      state     <= state_n;
      up_q      <= up;
      vel       <= vel_n;
      lfsr      <= lfsr_n;
      gap       <= gap_n;
      jump_req  <= jump_req_n;
      dino_y    <= dino_y_n;
      obs_x     <= obs_x_n;
      obs_valid <= obs_valid_n;
      score     <= score_n;
    end
  end

endmodule
